// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - shared dma_engineer constants and FSM state encoding
//
// Purpose: widths and state encoding shared by the layer controllers and
//          the dma_engineer read responder.
// Contents: DMA_ADDR_W, DMA_DATA_W, dma_state_e (ST_IDLE, ST_ACK, ST_RUN).
package dma_pkg;

  localparam int DMA_ADDR_W = 27;
  localparam int DMA_DATA_W = 512;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_RUN  = 2'd2
  } dma_state_e;

endpackage

// File: rtl/dma_rd_issue.sv
// rtl/dma_rd_issue.sv - beat issue counter and outstanding-read credit limiter
//
// Purpose: generates beat-granular memory read requests for one command,
//          limiting reads accepted but not yet returned to MAX_OUTSTANDING.
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   clear        restart counters for a new command
//   run          command is in its transfer phase
//   base_addr    first beat address of the command
//   len          beat count of the command
//   ret          a read beat is being returned this cycle
//   mem_rd_rdy   memory accepts the request this cycle
//   mem_rd_req   read request valid
//   mem_rd_addr  beat address of the request
import dma_pkg::*;

module dma_rd_issue #(
  parameter int ADDR_W          = DMA_ADDR_W,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              run,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] len,
  input  logic              ret,
  input  logic              mem_rd_rdy,
  output logic              mem_rd_req,
  output logic [ADDR_W-1:0] mem_rd_addr
);

  localparam int OUT_W = $clog2(MAX_OUTSTANDING) + 1;

  logic [ADDR_W-1:0] issued_q, issued_d;
  logic [OUT_W-1:0]  out_q, out_d;
  logic              accept;

  always_comb begin
    // Request depends only on registered state, so an unaccepted request
    // and its address stay stable until the memory takes it.
    mem_rd_req  = run && (issued_q < len) && (out_q < OUT_W'(MAX_OUTSTANDING));
    mem_rd_addr = base_addr + issued_q;
    accept      = mem_rd_req && mem_rd_rdy;
    issued_d    = issued_q;
    out_d       = out_q;
    if (clear) begin
      issued_d = '0;
      out_d    = '0;
    end else begin
      if (accept) begin
        issued_d = issued_q + ADDR_W'(1);
      end
      // Accept and return in the same cycle cancel out.
      if (accept && !ret) begin
        out_d = out_q + OUT_W'(1);
      end else if (!accept && ret) begin
        out_d = out_q - OUT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issued_q <= '0;
      out_q    <= '0;
    end else begin
      issued_q <= issued_d;
      out_q    <= out_d;
    end
  end

endmodule

// File: rtl/dma_engineer_rd.sv
// rtl/dma_engineer_rd.sv - dma_engineer read responder between a layer and memory
//
// Purpose: accepts one read command per req/ack handshake, issues beat reads
//          to the memory read port and streams the returned beats in order.
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   dma_engineer_req         level command request, held until ack
//   dma_engineer_ack         one-cycle command-captured pulse
//   dma_engineer_start_addr  first beat address
//   dma_engineer_length      beat count
//   dma_engineer_dout        returned beat, holds when dout_en is low
//   dma_engineer_dout_en     beat valid (no backpressure)
//   dma_engineer_dout_eop    marks the last beat of the command
//   mem_rd_req/addr/rdy      memory read request channel
//   mem_rd_valid/data        in-order memory read data
//   busy                     high from ack through the eop cycle
import dma_pkg::*;

module dma_engineer_rd #(
  parameter int          ADDR_W          = DMA_ADDR_W,
  parameter int          DATA_W          = DMA_DATA_W,
  parameter int          MAX_OUTSTANDING = 8,
  parameter int unsigned BASE_ADDR       = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dma_engineer_req,
  output logic              dma_engineer_ack,
  input  logic [ADDR_W-1:0] dma_engineer_start_addr,
  input  logic [ADDR_W-1:0] dma_engineer_length,
  output logic [DATA_W-1:0] dma_engineer_dout,
  output logic              dma_engineer_dout_en,
  output logic              dma_engineer_dout_eop,
  output logic              mem_rd_req,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic              mem_rd_rdy,
  input  logic              mem_rd_valid,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              busy
);

  dma_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] recv_q, recv_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              dout_en_q, dout_en_d;
  logic              eop_q, eop_d;
  logic              clear, run, ret;

  always_comb begin
    state_d          = state_q;
    addr_d           = addr_q;
    len_d            = len_q;
    recv_d           = recv_q;
    dout_d           = dout_q;
    dout_en_d        = 1'b0;
    eop_d            = 1'b0;
    dma_engineer_ack = 1'b0;
    clear            = 1'b0;
    run              = 1'b0;
    ret              = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // The eop cycle still counts as busy; req is looked at only once it
        // has passed, which puts a new ack two cycles after the eop.
        if (dma_engineer_req && !eop_q) begin
          addr_d  = dma_engineer_start_addr + ADDR_W'(BASE_ADDR);
          len_d   = dma_engineer_length;
          state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        dma_engineer_ack = 1'b1;
        clear            = 1'b1;
        recv_d           = '0;
        state_d          = (len_q == '0) ? ST_IDLE : ST_RUN;
      end
      ST_RUN: begin
        run = 1'b1;
        if (mem_rd_valid) begin
          ret       = 1'b1;
          dout_d    = mem_rd_data;
          dout_en_d = 1'b1;
          recv_d    = recv_q + ADDR_W'(1);
          if (recv_q == len_q - ADDR_W'(1)) begin
            eop_d   = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      len_q     <= '0;
      recv_q    <= '0;
      dout_q    <= '0;
      dout_en_q <= 1'b0;
      eop_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      recv_q    <= recv_d;
      dout_q    <= dout_d;
      dout_en_q <= dout_en_d;
      eop_q     <= eop_d;
    end
  end

  assign dma_engineer_dout     = dout_q;
  assign dma_engineer_dout_en  = dout_en_q;
  assign dma_engineer_dout_eop = eop_q;
  assign busy                  = (state_q != ST_IDLE) || eop_q;

  dma_rd_issue #(
    .ADDR_W          (ADDR_W),
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) u_issue (
    .clk         (clk),
    .rst         (rst),
    .clear       (clear),
    .run         (run),
    .base_addr   (addr_q),
    .len         (len_q),
    .ret         (ret),
    .mem_rd_rdy  (mem_rd_rdy),
    .mem_rd_req  (mem_rd_req),
    .mem_rd_addr (mem_rd_addr)
  );

endmodule

// File: tb/tb_dma_engineer_rd.sv
// tb/tb_dma_engineer_rd.sv - directed self-checking bench for dma_engineer_rd
module tb_dma_engineer_rd;

  localparam int AW   = 27;
  localparam int DW   = 512;
  localparam int MAXO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req = 1'b0;
  logic          ack;
  logic [AW-1:0] start_addr = '0;
  logic [AW-1:0] length = '0;
  logic [DW-1:0] dout;
  logic          dout_en, dout_eop;
  logic          mem_rd_req;
  logic [AW-1:0] mem_rd_addr;
  logic          mem_rd_rdy;
  logic          mem_rd_valid;
  logic [DW-1:0] mem_rd_data;
  logic          busy;

  always #5 clk = ~clk;

  dma_engineer_rd #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_OUTSTANDING(MAXO), .BASE_ADDR(0)
  ) dut (
    .clk(clk), .rst(rst),
    .dma_engineer_req(req), .dma_engineer_ack(ack),
    .dma_engineer_start_addr(start_addr), .dma_engineer_length(length),
    .dma_engineer_dout(dout), .dma_engineer_dout_en(dout_en),
    .dma_engineer_dout_eop(dout_eop),
    .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr), .mem_rd_rdy(mem_rd_rdy),
    .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
    .busy(busy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [AW-1:0] addr;
    int            due;
  } rd_t;

  rd_t           pend[$];
  logic [DW-1:0] beat_data[$];
  bit            beat_eop[$];
  int            ack_cyc[$];
  int            eop_cyc[$];
  logic [AW-1:0] acc_addr[$];
  bit            hold_ret = 1'b0;
  int            rdy_mode = 1;
  int            model_out = 0;
  int            max_out = 0;
  int            cred_err = 0;
  int            hold_err = 0;
  int            req_cnt = 0;
  bit            prev_pend = 1'b0;
  logic [AW-1:0] prev_addr = '0;

  // Memory model and output monitor; acts on falling edges only.
  initial begin
    rd_t e;
    mem_rd_valid = 1'b0;
    mem_rd_data  = '0;
    mem_rd_rdy   = 1'b1;
    forever begin
      @(negedge clk);
      if (ack) ack_cyc.push_back(cyc);
      if (dout_en) begin
        beat_data.push_back(dout);
        beat_eop.push_back(dout_eop);
        if (dout_eop) eop_cyc.push_back(cyc);
      end
      if (mem_rd_req) req_cnt++;
      if (mem_rd_req && model_out >= MAXO) cred_err++;
      if (prev_pend && (!mem_rd_req || mem_rd_addr !== prev_addr)) hold_err++;
      if (model_out > max_out) max_out = model_out;
      if (rdy_mode == 0) mem_rd_rdy = 1'b0;
      else if (rdy_mode == 1) mem_rd_rdy = 1'b1;
      else mem_rd_rdy = ~mem_rd_rdy;
      mem_rd_valid = 1'b0;
      if (!hold_ret && pend.size() > 0 && pend[0].due <= cyc) begin
        mem_rd_valid = 1'b1;
        mem_rd_data  = DW'(pend[0].addr);
        void'(pend.pop_front());
        if (model_out > 0) model_out--;
      end
      if (rst) begin
        model_out = 0;
        prev_pend = 1'b0;
      end else begin
        if (mem_rd_req && mem_rd_rdy) begin
          e.addr = mem_rd_addr;
          e.due  = cyc + 2;
          pend.push_back(e);
          acc_addr.push_back(mem_rd_addr);
          model_out++;
        end
        prev_pend = mem_rd_req && !mem_rd_rdy;
        prev_addr = mem_rd_addr;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic clear_logs();
    @(posedge clk); #1;
    beat_data.delete(); beat_eop.delete(); ack_cyc.delete();
    eop_cyc.delete(); acc_addr.delete();
    max_out = 0; cred_err = 0; hold_err = 0; req_cnt = 0;
  endtask

  task automatic start_cmd(input logic [AW-1:0] a, input logic [AW-1:0] l);
    bit seen = 1'b0;
    @(posedge clk); #1;
    start_addr = a; length = l; req = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (ack) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL ack_timeout got no ack expected ack within 20 cycles");
    end
    @(posedge clk); #1;
    req = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk); #1;
      if (!busy && pend.size() == 0) done = 1'b1;
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL idle_timeout got busy=%0b pend=%0d expected idle", busy, pend.size());
    end
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL rst_ack got %0b expected 0", ack); end
    n_checks++; if (dout_en !== 1'b0) begin n_fail++; $display("FAIL rst_dout_en got %0b expected 0", dout_en); end
    n_checks++; if (dout_eop !== 1'b0) begin n_fail++; $display("FAIL rst_eop got %0b expected 0", dout_eop); end
    n_checks++; if (dout !== '0) begin n_fail++; $display("FAIL rst_dout got %0h expected 0", dout); end
    n_checks++; if (mem_rd_req !== 1'b0) begin n_fail++; $display("FAIL rst_mem_req got %0b expected 0", mem_rd_req); end
    n_checks++; if (mem_rd_addr !== '0) begin n_fail++; $display("FAIL rst_mem_addr got %0h expected 0", mem_rd_addr); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %0b expected 0", busy); end
  endtask

  task automatic test_basic();
    int bad = 0;
    int neop = 0;
    clear_logs();
    rdy_mode = 1;
    start_cmd(27'd0, 27'd128);
    wait_idle(1000);
    n_checks++; if (ack_cyc.size() != 1) begin n_fail++; $display("FAIL basic_acks got %0d expected 1", ack_cyc.size()); end
    n_checks++; if (beat_data.size() != 128) begin n_fail++; $display("FAIL basic_beats got %0d expected 128", beat_data.size()); end
    for (int i = 0; i < beat_data.size(); i++) begin
      if (beat_data[i] !== DW'(i)) bad++;
      if (beat_eop[i]) neop++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL basic_data got %0d wrong beats expected 0", bad); end
    n_checks++; if (neop != 1) begin n_fail++; $display("FAIL basic_eop_count got %0d expected 1", neop); end
    if (beat_eop.size() == 128) begin
      n_checks++; if (beat_eop[127] !== 1'b1) begin n_fail++; $display("FAIL basic_eop_last got %0b expected 1", beat_eop[127]); end
    end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_after got %0b expected 0", busy); end
  endtask

  task automatic test_credit();
    int bad = 0;
    clear_logs();
    hold_ret = 1'b1;
    start_cmd(27'h1000, 27'd20);
    repeat (30) @(posedge clk);
    #1;
    n_checks++; if (acc_addr.size() != 8) begin n_fail++; $display("FAIL credit_accepts_held got %0d expected 8", acc_addr.size()); end
    n_checks++; if (mem_rd_req !== 1'b0) begin n_fail++; $display("FAIL credit_req_drop got %0b expected 0", mem_rd_req); end
    hold_ret = 1'b0;
    wait_idle(500);
    n_checks++; if (max_out != 8) begin n_fail++; $display("FAIL credit_max_out got %0d expected 8", max_out); end
    n_checks++; if (cred_err != 0) begin n_fail++; $display("FAIL credit_over_issue got %0d expected 0", cred_err); end
    n_checks++; if (acc_addr.size() != 20) begin n_fail++; $display("FAIL credit_accepts got %0d expected 20", acc_addr.size()); end
    n_checks++; if (beat_data.size() != 20) begin n_fail++; $display("FAIL credit_beats got %0d expected 20", beat_data.size()); end
    for (int i = 0; i < beat_data.size(); i++) begin
      if (beat_data[i] !== DW'(32'h1000 + i)) bad++;
      if (beat_eop[i] !== (i == 19)) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL credit_data_eop got %0d errors expected 0", bad); end
  endtask

  task automatic test_backpressure();
    logic [AW-1:0] exp_addr[4];
    int bad = 0;
    exp_addr[0] = 27'h7FFFFFE; exp_addr[1] = 27'h7FFFFFF;
    exp_addr[2] = 27'h0000000; exp_addr[3] = 27'h0000001;
    clear_logs();
    rdy_mode = 2;
    start_cmd(27'h7FFFFFE, 27'd4);
    wait_idle(200);
    rdy_mode = 1;
    n_checks++; if (acc_addr.size() != 4) begin n_fail++; $display("FAIL bp_accepts got %0d expected 4", acc_addr.size()); end
    for (int i = 0; i < 4 && i < acc_addr.size(); i++) begin
      n_checks++;
      if (acc_addr[i] !== exp_addr[i]) begin n_fail++; $display("FAIL bp_addr%0d got %0h expected %0h", i, acc_addr[i], exp_addr[i]); end
    end
    n_checks++; if (hold_err != 0) begin n_fail++; $display("FAIL bp_hold got %0d drops expected 0", hold_err); end
    n_checks++; if (beat_data.size() != 4) begin n_fail++; $display("FAIL bp_beats got %0d expected 4", beat_data.size()); end
    for (int i = 0; i < beat_data.size() && i < 4; i++) begin
      if (beat_data[i] !== DW'(exp_addr[i])) bad++;
      if (beat_eop[i] !== (i == 3)) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL bp_data_eop got %0d errors expected 0", bad); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp_d[4];
    bit            exp_e[4];
    int bad = 0;
    exp_d[0] = DW'(32'h100); exp_d[1] = DW'(32'h200);
    exp_d[2] = DW'(32'h201); exp_d[3] = DW'(32'h202);
    exp_e[0] = 1'b1; exp_e[1] = 1'b0; exp_e[2] = 1'b0; exp_e[3] = 1'b1;
    clear_logs();
    start_addr = 27'h100; length = 27'd1; req = 1'b1;
    for (int i = 0; i < 20 && ack_cyc.size() < 1; i++) begin
      @(negedge clk); #1;
    end
    @(posedge clk); #1;
    start_addr = 27'h200; length = 27'd3;
    for (int i = 0; i < 50 && ack_cyc.size() < 2; i++) begin
      @(negedge clk); #1;
    end
    @(posedge clk); #1;
    req = 1'b0;
    wait_idle(100);
    n_checks++; if (ack_cyc.size() != 2) begin n_fail++; $display("FAIL b2b_acks got %0d expected 2", ack_cyc.size()); end
    n_checks++; if (eop_cyc.size() != 2) begin n_fail++; $display("FAIL b2b_eops got %0d expected 2", eop_cyc.size()); end
    if (ack_cyc.size() == 2 && eop_cyc.size() >= 1) begin
      n_checks++;
      if (ack_cyc[1] - eop_cyc[0] < 2) begin
        n_fail++; $display("FAIL b2b_ack_gap got %0d expected >=2", ack_cyc[1] - eop_cyc[0]);
      end
    end
    n_checks++; if (beat_data.size() != 4) begin n_fail++; $display("FAIL b2b_beats got %0d expected 4", beat_data.size()); end
    for (int i = 0; i < beat_data.size() && i < 4; i++) begin
      if (beat_data[i] !== exp_d[i]) bad++;
      if (beat_eop[i] !== exp_e[i]) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL b2b_data_eop got %0d errors expected 0", bad); end
  endtask

  task automatic test_reset_mid();
    int nb;
    int bad = 0;
    clear_logs();
    start_cmd(27'h300, 27'd16);
    for (int i = 0; i < 100 && beat_data.size() < 5; i++) begin
      @(negedge clk); #1;
    end
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ack got %0b expected 0", ack); end
    n_checks++; if (dout_en !== 1'b0) begin n_fail++; $display("FAIL mid_rst_dout_en got %0b expected 0", dout_en); end
    n_checks++; if (dout_eop !== 1'b0) begin n_fail++; $display("FAIL mid_rst_eop got %0b expected 0", dout_eop); end
    n_checks++; if (dout !== '0) begin n_fail++; $display("FAIL mid_rst_dout got %0h expected 0", dout); end
    n_checks++; if (mem_rd_req !== 1'b0) begin n_fail++; $display("FAIL mid_rst_mem_req got %0b expected 0", mem_rd_req); end
    n_checks++; if (mem_rd_addr !== '0) begin n_fail++; $display("FAIL mid_rst_mem_addr got %0h expected 0", mem_rd_addr); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy got %0b expected 0", busy); end
    #1 nb = beat_data.size();
    wait_idle(100);
    n_checks++; if (beat_data.size() != nb) begin n_fail++; $display("FAIL mid_stray_beats got %0d expected %0d", beat_data.size(), nb); end
    clear_logs();
    start_cmd(27'h40, 27'd2);
    wait_idle(100);
    n_checks++; if (beat_data.size() != 2) begin n_fail++; $display("FAIL mid_new_beats got %0d expected 2", beat_data.size()); end
    for (int i = 0; i < beat_data.size() && i < 2; i++) begin
      if (beat_data[i] !== DW'(32'h40 + i)) bad++;
      if (beat_eop[i] !== (i == 1)) bad++;
    end
    n_checks++; if (bad != 0) begin n_fail++; $display("FAIL mid_new_data_eop got %0d errors expected 0", bad); end
  endtask

  task automatic test_zero_len();
    clear_logs();
    start_addr = 27'h500; length = 27'd0; req = 1'b1;
    @(negedge clk);
    n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL zero_ack_early got %0b expected 0", ack); end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if (ack !== 1'b1) begin n_fail++; $display("FAIL zero_ack got %0b expected 1", ack); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL zero_busy_ack got %0b expected 1", busy); end
    @(posedge clk); #1 req = 1'b0;
    @(negedge clk);
    n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL zero_ack_after got %0b expected 0", ack); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL zero_idle got busy=%0b expected 0", busy); end
    repeat (5) @(negedge clk);
    #1;
    n_checks++; if (ack_cyc.size() != 1) begin n_fail++; $display("FAIL zero_acks got %0d expected 1", ack_cyc.size()); end
    n_checks++; if (req_cnt != 0) begin n_fail++; $display("FAIL zero_mem_req got %0d cycles expected 0", req_cnt); end
    n_checks++; if (beat_data.size() != 0) begin n_fail++; $display("FAIL zero_beats got %0d expected 0", beat_data.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_credit();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_zero_len();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
